rr_arbiter16: RTL
=================

# rr_arbiter16

Sixteen-requester round-robin arbiter that shares one resource among sixteen agents and drives a one-hot grant vector. The winner is held as a 4-bit index and expanded to sixteen lines through a 4-to-16 decode gated by grant-valid. It sits between the requesting agents and the shared resource, and provides fairness, bounded hold time and a bus-turnaround idle cycle.

## Interface
- HOLD_MAX, 16, maximum cycles a grant is held without `done`; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  16  request level per agent; bit i belongs to agent i.
- done  in  1  release from the current owner; sampled only in GRANT.
- gnt  out  16  one-hot grant; all zero when no grant is active.
- gnt_id  out  4  index of the current or most recent owner.
- gnt_valid  out  1  grant active.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State machine with two states: IDLE and GRANT. All outputs are registered.
- Round-robin pointer `ptr[3:0]` sets the first candidate for the next arbitration. Reset value is 0.
- IDLE, when `req != 0`: the winner is the first set bit scanning `ptr, ptr+1, ... ptr+15`, modulo 16.
  - Next edge: `gnt_id` = winner, `gnt_valid` = 1, `ptr` = winner+1 (mod 16, so 15 wraps to 0), hold counter = 0, state = GRANT.
- IDLE, when `req == 0`: stay in IDLE and hold `gnt_id` at its last value.
- `gnt = gnt_valid ? (16'b1 << gnt_id) : 16'b0`, decoded from the registered `gnt_id` and `gnt_valid`.
- GRANT, release conditions (evaluated every cycle):
  - `done` = 1;
  - or `req[gnt_id]` = 0;
  - or hold counter = HOLD_MAX-1.
- On release: next edge `gnt_valid` = 0, state = IDLE.
  - `timeout` = 1 for that one cycle only when the hold limit caused the release and neither `done` nor a req drop was present.
  - `done` or a req drop has priority over timeout.
- GRANT, no release condition: hold counter increments. The counter is 8 bits wide and cannot overflow because it stops at HOLD_MAX-1.
- `done` in IDLE is ignored.
- Requests from non-owners during GRANT have no effect. They are considered at the next IDLE cycle.
- The pointer update makes a continuously requesting agent wait at most 15 grants.
- `rst` asserted at any time, including mid-grant:
  - immediately forces `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `timeout` = 0, `ptr` = 0, counter = 0, state = IDLE;
  - the first arbitration after reset deasserts uses `ptr` = 0.

## Timing
- Grant latency: `req` seen in IDLE at edge N gives `gnt` high after edge N (visible in cycle N+1).
- Release latency: a release condition seen at edge M gives `gnt` low after edge M.
- At least one IDLE cycle (turnaround) always separates two grants. Back-to-back grant spacing is 1 IDLE cycle.
- Hold bound: with `done` held low, `gnt_valid` stays high for exactly HOLD_MAX cycles. `timeout` pulses in the first IDLE cycle after that.
- HOLD_MAX = 1: every grant lasts one cycle. `timeout` pulses after each grant that ends without `done` or a req drop.
- Simultaneous `done` and hold limit: the release is counted as normal and `timeout` stays 0.
- Requester drops req in the same cycle the grant appears: the release is taken at the next edge. The grant lasts 1 cycle and `timeout` stays 0.

## Test plan
- Reset: assert `rst` with `req` = 16'hFFFF -> `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0, `timeout` = 0. Deassert -> first grant goes to agent 0 (`gnt` = 16'h0001).
- Single requester: `req` = 16'h0020 (agent 5), `done` pulsed 3 cycles after the grant -> `gnt` = 16'h0020 for 4 cycles, then 1 IDLE cycle, then re-granted to agent 5 while its req stays high.
- Fairness: `req` = 16'h1088 held (agents 3, 7, 12), `done` pulsed each grant -> grant order 3, 7, 12, 3, 7 with one IDLE cycle between grants.
- Wrap-around: `ptr` at 15 after agent 14 is granted, `req` = 16'h8001 -> agent 15 is granted, then agent 0, then agent 15.
- Timeout: HOLD_MAX = 4, `req` = 16'h0100 held, `done` = 0 -> `gnt` = 16'h0100 for exactly 4 cycles, `timeout` pulses 1 cycle, then re-grant after 1 IDLE cycle. Repeat with `done` on the 4th cycle -> `timeout` stays 0.
- Reset mid-grant: agent 9 granted, `rst` asserted between edges -> `gnt` goes to 0 asynchronously. After release with `req` = 16'h0600 -> agent 9 is granted (`ptr` restarts at 0, scan finds 9 before 10).

Source files
------------

// File: rtl/rr_arbiter16.sv
// Sixteen-requester round-robin arbiter with a one-hot registered grant,
// a bounded hold time and one idle turnaround cycle between grants.
module rr_arbiter16 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_ptr;
  logic [3:0]  w_ptr_nxt;
  logic [3:0]  r_id;
  logic [3:0]  w_id_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic        r_timeout;
  logic        w_timeout_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] r_gnt;
  logic [15:0] w_gnt_nxt;
  logic [3:0]  w_idx;
  logic [3:0]  w_winner;
  logic        w_found;
  logic        w_rel_normal;
  logic        w_rel_hold;

  // First requester at or after r_ptr, wrapping modulo 16.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      w_idx = r_ptr + 4'(k);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign w_rel_normal = done | ~req[r_id];
  assign w_rel_hold   = (r_cnt == HOLD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_id_nxt      = r_id;
    w_valid_nxt   = r_valid;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_id_nxt    = w_winner;
          w_valid_nxt = 1'b1;
          w_ptr_nxt   = w_winner + 4'd1;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (w_rel_normal || w_rel_hold) begin
          w_state_nxt   = ST_IDLE;
          w_valid_nxt   = 1'b0;
          w_timeout_nxt = ~w_rel_normal;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    // Decode from next-state values so the one-hot vector is itself a register.
    w_gnt_nxt = w_valid_nxt ? (16'h0001 << w_id_nxt) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_gnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_id      <= w_id_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt     <= w_gnt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_id;
  assign gnt_valid = r_valid;
  assign timeout   = r_timeout;

endmodule
